// File: rtl/ahb_lite_cmd_master_if.sv
// Command stream and AHB-Lite initiator signals of ahb_lite_cmd_master.
// The master modport is the initiator's view; slave is the bus/command-source view.
interface ahb_lite_cmd_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [2:0]  cmd_size;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_size, HREADY, HRDATA,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               HSEL, HADDR, HWRITE, HTRANS, HSIZE, HWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_size, HREADY, HRDATA,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               HSEL, HADDR, HWRITE, HTRANS, HSIZE, HWDATA
    );
endinterface

// File: rtl/ahb_lite_cmd_master.sv
// AHB-Lite initiator: one valid/ready command becomes one NONSEQ single transfer,
// with wait-state handling, a stall timeout and a one-cycle response strobe.
module ahb_lite_cmd_master #(
    parameter int unsigned TIMEOUT_W  = 8,
    parameter bit          TIMEOUT_EN = 1'b1
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    ahb_lite_cmd_master_if.master bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    // Last stall count before abort: the next stalled edge would be stall number 2**W-1
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'((64'd1 << TIMEOUT_W) - 64'd2);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_e;

    state_e               state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 rsp_timeout_q, rsp_timeout_d;
    logic                 hsel_q, hsel_d;
    logic [ADDR_W-1:0]    haddr_q, haddr_d;
    logic                 hwrite_q, hwrite_d;
    logic [1:0]           htrans_q, htrans_d;
    logic [2:0]           hsize_q, hsize_d;
    logic [DATA_W-1:0]    hwdata_q, hwdata_d;
    logic                 cmd_illegal_c;
    logic                 stall_limit_c;

    // Size above word, or address not aligned to the transfer size
    assign cmd_illegal_c = (bus.cmd_size > 3'd2)
                         || ((bus.cmd_size == 3'd1) && bus.cmd_addr[0])
                         || ((bus.cmd_size == 3'd2) && (bus.cmd_addr[1:0] != 2'b00));
    assign stall_limit_c = TIMEOUT_EN && (cnt_q == CNT_LAST);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            wdata_q       <= '0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            hsel_q        <= 1'b0;
            haddr_q       <= '0;
            hwrite_q      <= 1'b0;
            htrans_q      <= HTRANS_IDLE;
            hsize_q       <= 3'd0;
            hwdata_q      <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wdata_q       <= wdata_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            hsel_q        <= hsel_d;
            haddr_q       <= haddr_d;
            hwrite_q      <= hwrite_d;
            htrans_q      <= htrans_d;
            hsize_q       <= hsize_d;
            hwdata_q      <= hwdata_d;
        end
    end

    // Next state plus next value of every registered output
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wdata_d       = wdata_q;
        cmd_ready_d   = 1'b0;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = '0;
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;
        hsel_d        = 1'b0;
        htrans_d      = HTRANS_IDLE;
        haddr_d       = haddr_q;
        hwrite_d      = hwrite_q;
        hsize_d       = hsize_q;
        hwdata_d      = hwdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    if (cmd_illegal_c) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d  = ST_ADDR;
                        hsel_d   = 1'b1;
                        htrans_d = HTRANS_NONSEQ;
                        haddr_d  = bus.cmd_addr;
                        hwrite_d = bus.cmd_write;
                        hsize_d  = bus.cmd_size;
                        wdata_d  = bus.cmd_wdata;
                        cnt_d    = '0;
                    end
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            ST_ADDR: begin
                if (bus.HREADY) begin
                    state_d  = ST_DATA;
                    cnt_d    = '0;
                    hwdata_d = hwrite_q ? wdata_q : hwdata_q;
                end else if (stall_limit_c) begin
                    state_d       = ST_RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    hsel_d   = 1'b1;
                    htrans_d = HTRANS_NONSEQ;
                    cnt_d    = cnt_q + TIMEOUT_W'(1);
                end
            end
            ST_DATA: begin
                if (bus.HREADY) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = hwrite_q ? '0 : bus.HRDATA;
                end else if (stall_limit_c) begin
                    state_d       = ST_RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
            end
            ST_RESP: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.HSEL        = hsel_q;
    assign bus.HADDR       = haddr_q;
    assign bus.HWRITE      = hwrite_q;
    assign bus.HTRANS      = htrans_q;
    assign bus.HSIZE       = hsize_q;
    assign bus.HWDATA      = hwdata_q;
endmodule
